// File: rtl/tx_am_inserter.sv
// tx_am_inserter
//   Transmit-side alignment marker inserter for the multi-lane 25G PCS.
//   Forwards encoded/scrambled lane blocks to the gearbox. After every
//   AM_PERIOD data blocks it substitutes one alignment marker (AM) per lane.
//   The marker carries that lane's 3-bit id so the receiver can lock and
//   reorder its lanes. There is a single output register stage, and
//   valid/ready handshakes are used on both sides.
//
//   AM layout for lane k:
//     [7:0]            AM_TAG (its bits [1:0] form the control sync header)
//     [10:8]           lane id, taken from cfg_lane_id[3k+2:3k]
//     [11]             0
//     [UNITWIDTH-1:12] AM_FILL replicated
//                      (with TX_AM_BIP_EN: [19:12] = lane BIP-8,
//                       and AM_FILL covers [UNITWIDTH-1:20])
//
//   Optional feature macro: TX_AM_BIP_EN
//     When defined, a BIP-8 per lane accumulates over the data blocks that
//     leave the output register. Each AM carries the lane's BIP.
//
// Ports:
//   clk, reset_n      clock and synchronous active-low reset
//   in_enable         block enable; low forces IDLE and stops new loads
//   cfg_lane_id       lane ids, 3 bits per lane; sampled when an AM is loaded
//   in_txdata         input blocks, lane k at [k*UNITWIDTH +: UNITWIDTH]
//   in_txdata_valid   upstream block valid
//   in_ready          upstream may transfer (combinational from out_ready)
//   out_txdata        output register contents to the gearbox
//   out_txdata_valid  output register holds a block
//   out_ready         gearbox accepts this cycle
//   out_am_flag       output register holds an AM
//   out_am_count      saturating count of AMs loaded since reset
module tx_am_inserter #(
  parameter int         LANES     = 4,
  parameter int         UNITWIDTH = 66,
  parameter int         AM_PERIOD = 16384,
  parameter logic [7:0] AM_TAG    = 8'hC1,
  parameter logic       AM_FILL   = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_enable,
  input  logic [LANES*3-1:0]         cfg_lane_id,
  input  logic [UNITWIDTH*LANES-1:0] in_txdata,
  input  logic                       in_txdata_valid,
  output logic                       in_ready,
  output logic [UNITWIDTH*LANES-1:0] out_txdata,
  output logic                       out_txdata_valid,
  input  logic                       out_ready,
  output logic                       out_am_flag,
  output logic [15:0]                out_am_count
);

  localparam int            CW       = (AM_PERIOD > 2) ? $clog2(AM_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(AM_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AM   = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                     state;
  logic [CW-1:0]              blk_cnt;
  logic                       slot_free;
  logic                       out_xfer;
  logic                       in_xfer;
  logic [UNITWIDTH*LANES-1:0] am_word;

  assign slot_free = !out_txdata_valid || out_ready;
  assign out_xfer  = out_txdata_valid && out_ready;
  assign in_ready  = in_enable && (state == DATA) && slot_free;
  assign in_xfer   = in_txdata_valid && in_ready;

  function automatic logic [UNITWIDTH-1:0] am_base(input logic [2:0] id);
    logic [UNITWIDTH-1:0] b;
    b       = {UNITWIDTH{AM_FILL}};
    b[7:0]  = AM_TAG;
    b[10:8] = id;
    b[11]   = 1'b0;
    return b;
  endfunction

`ifdef TX_AM_BIP_EN
  logic [7:0] bip_acc  [LANES];
  logic [7:0] bip_next [LANES];

  // Fold a block into 8 interleaved parity bits (bit i covers j%8==i).
  function automatic logic [7:0] bip_fold(input logic [UNITWIDTH-1:0] d);
    logic [7:0] f;
    f = '0;
    for (int j = 0; j < UNITWIDTH; j++) begin
      f[j % 8] = f[j % 8] ^ d[j];
    end
    return f;
  endfunction

  // The next-state BIP includes a data block that leaves on this same edge.
  // This lets an AM loaded on that edge cover every block sent before it.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      bip_next[k] = bip_acc[k];
      if (out_xfer && !out_am_flag) begin
        bip_next[k] = bip_acc[k] ^ bip_fold(out_txdata[k*UNITWIDTH +: UNITWIDTH]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (!reset_n || !in_enable || (out_xfer && out_am_flag)) begin
        bip_acc[k] <= '0;
      end else begin
        bip_acc[k] <= bip_next[k];
      end
    end
  end

  always_comb begin
    am_word = '0;
    for (int k = 0; k < LANES; k++) begin
      am_word[k*UNITWIDTH +: UNITWIDTH]      = am_base(cfg_lane_id[3*k +: 3]);
      am_word[k*UNITWIDTH + 12 +: 8]         = bip_next[k];
    end
  end
`else
  always_comb begin
    am_word = '0;
    for (int k = 0; k < LANES; k++) begin
      am_word[k*UNITWIDTH +: UNITWIDTH] = am_base(cfg_lane_id[3*k +: 3]);
    end
  end
`endif

  // Output register stage: FSM, block counter and marker substitution
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      blk_cnt          <= '0;
      out_txdata       <= '0;
      out_txdata_valid <= 1'b0;
      out_am_flag      <= 1'b0;
      out_am_count     <= '0;
    end else begin
      // An emptied slot with nothing new to load drains to invalid.
      // The load branches below override this.
      if (slot_free) begin
        out_txdata_valid <= 1'b0;
        out_am_flag      <= 1'b0;
      end
      if (!in_enable) begin
        state   <= IDLE;
        blk_cnt <= '0;
      end else begin
        case (state)
          IDLE: state <= AM;
          AM: begin
            if (slot_free) begin
              out_txdata       <= am_word;
              out_txdata_valid <= 1'b1;
              out_am_flag      <= 1'b1;
              blk_cnt          <= '0;
              if (out_am_count != 16'hFFFF) begin
                out_am_count <= out_am_count + 16'd1;
              end
              state <= DATA;
            end
          end
          DATA: begin
            if (in_xfer) begin
              out_txdata       <= in_txdata;
              out_txdata_valid <= 1'b1;
              out_am_flag      <= 1'b0;
              if (blk_cnt == CNT_LAST) begin
                blk_cnt <= '0;
                state   <= AM;
              end else begin
                blk_cnt <= blk_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_am_inserter.sv
module tb_tx_am_inserter;

  localparam int LANES = 4;
  localparam int UW    = 66;
  localparam int W     = LANES * UW;

  logic          clk;
  logic          reset_n;
  logic          in_enable;
  logic [11:0]   cfg_lane_id;
  logic [W-1:0]  in_txdata;
  logic          in_txdata_valid;
  logic          in_ready;
  logic [W-1:0]  out_txdata;
  logic          out_txdata_valid;
  logic          out_ready;
  logic          out_am_flag;
  logic [15:0]   out_am_count;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] amask;
  logic [W-1:0] ones;
  logic [W-1:0] e;

  tx_am_inserter #(
    .LANES(LANES), .UNITWIDTH(UW), .AM_PERIOD(4), .AM_TAG(8'hC1), .AM_FILL(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_enable(in_enable), .cfg_lane_id(cfg_lane_id),
    .in_txdata(in_txdata), .in_txdata_valid(in_txdata_valid), .in_ready(in_ready),
    .out_txdata(out_txdata), .out_txdata_valid(out_txdata_valid), .out_ready(out_ready),
    .out_am_flag(out_am_flag), .out_am_count(out_am_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Distinct data block n: lane k = {2'b01, 16'hA5A5, k, n}
  function automatic logic [W-1:0] dat(input int n);
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*UW +: UW] = {2'b01, 16'hA5A5, 16'(k), 32'(n)};
    return r;
  endfunction

  // Expected marker from the lane-id configuration (fill bits all ones)
  function automatic logic [W-1:0] am_exp(input logic [11:0] ids);
    logic [W-1:0]  r;
    logic [UW-1:0] b;
    for (int k = 0; k < LANES; k++) begin
      b       = {UW{1'b1}};
      b[7:0]  = 8'hC1;
      b[10:8] = ids[3*k +: 3];
      b[11]   = 1'b0;
      r[k*UW +: UW] = b;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp,
                     input logic [W-1:0] msk);
    tests++;
    assert ((act & msk) === (exp & msk)) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, act & msk, exp & msk);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic ef,
                         input logic [W-1:0] ed, input logic [W-1:0] msk);
    chk({tag, "_valid"}, W'(out_txdata_valid), W'(ev), ones);
    chk({tag, "_flag"}, W'(out_am_flag), W'(ef), ones);
    if (ev) chk({tag, "_data"}, out_txdata, ed, msk);
  endtask

  initial begin
    ones  = '1;
    amask = '1;
`ifdef TX_AM_BIP_EN
    for (int k = 0; k < LANES; k++) amask[k*UW + 12 +: 8] = 8'h00;
`endif
    reset_n = 1'b0; in_enable = 1'b0; in_txdata_valid = 1'b0; out_ready = 1'b1;
    cfg_lane_id = 12'o3210; in_txdata = '0;
    tick(); tick();
    chk_out("rst", 1'b0, 1'b0, '0, ones);
    chk("rst_data", out_txdata, '0, ones);
    chk("rst_count", W'(out_am_count), W'(0), ones);
    chk("rst_ready", W'(in_ready), W'(0), ones);

    // Continuous flow: AM, D, D, D, D, AM, D, D, D, D
    reset_n = 1'b1; in_enable = 1'b1; in_txdata_valid = 1'b1; in_txdata = dat(0);
    tick();
    chk_out("t1_idle", 1'b0, 1'b0, '0, ones);
    chk("t1_idle_ready", W'(in_ready), W'(0), ones);
    tick();
    chk_out("t1_am1", 1'b1, 1'b1, am_exp(12'o3210), amask);
    chk("t1_cnt1", W'(out_am_count), W'(1), ones);
    chk("t1_ready_data", W'(in_ready), W'(1), ones);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("t1_d", 1'b1, 1'b0, dat(i), ones);
      in_txdata = dat(i + 1);
    end
    chk("t1_ready_am", W'(in_ready), W'(0), ones);
    tick();
    chk_out("t1_am2", 1'b1, 1'b1, am_exp(12'o3210), amask);
    for (int i = 4; i < 8; i++) begin
      tick();
      chk_out("t1_d2", 1'b1, 1'b0, dat(i), ones);
      in_txdata = dat(i + 1);
    end
    chk("t1_cnt_10beats", W'(out_am_count), W'(2), ones);

    // Stall during an AM and during data
    tick();
    chk_out("t3_am3", 1'b1, 1'b1, am_exp(12'o3210), amask);
    chk("t3_cnt3", W'(out_am_count), W'(3), ones);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("t3_am_hold", 1'b1, 1'b1, am_exp(12'o3210), amask);
      chk("t3_am_hold_ready", W'(in_ready), W'(0), ones);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_ready_release", W'(in_ready), W'(1), ones);
    tick();
    chk_out("t3_d8", 1'b1, 1'b0, dat(8), ones);
    in_txdata = dat(9); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("t3_d_hold", 1'b1, 1'b0, dat(8), ones);
      chk("t3_d_hold_ready", W'(in_ready), W'(0), ones);
    end
    out_ready = 1'b1;
    for (int i = 9; i < 12; i++) begin
      tick();
      chk_out("t3_d", 1'b1, 1'b0, dat(i), ones);
      in_txdata = dat(i + 1);
    end
    chk("t3_spacing_ready", W'(in_ready), W'(0), ones);
    tick();
    chk_out("t3_am4", 1'b1, 1'b1, am_exp(12'o3210), amask);
    chk("t3_cnt4", W'(out_am_count), W'(4), ones);

    // Toggled input valid: still 4 data transfers between markers
    for (int i = 12; i < 16; i++) begin
      in_txdata = dat(i); in_txdata_valid = 1'b1;
      tick();
      chk_out("t4_d", 1'b1, 1'b0, dat(i), ones);
      in_txdata_valid = 1'b0;
      tick();
      if (i < 15) chk_out("t4_gap", 1'b0, 1'b0, '0, ones);
      else        chk_out("t4_am5", 1'b1, 1'b1, am_exp(12'o3210), amask);
    end
    chk("t4_cnt5", W'(out_am_count), W'(5), ones);

    // Disable mid-DATA with the gearbox stalled
    in_txdata_valid = 1'b1; in_txdata = dat(16);
    tick();
    chk_out("t5_d16", 1'b1, 1'b0, dat(16), ones);
    out_ready = 1'b0; in_txdata = dat(17);
    tick();
    in_enable = 1'b0;
    tick();
    chk_out("t5_pending", 1'b1, 1'b0, dat(16), ones);
    out_ready = 1'b1;
    #1;
    chk("t5_ready_disabled", W'(in_ready), W'(0), ones);
    tick();
    chk_out("t5_drained", 1'b0, 1'b0, '0, ones);
    tick();
    chk_out("t5_idle", 1'b0, 1'b0, '0, ones);
    in_enable = 1'b1;
    tick();
    chk_out("t5_reen", 1'b0, 1'b0, '0, ones);
    tick();
    chk_out("t5_am6", 1'b1, 1'b1, am_exp(12'o3210), amask);
    chk("t5_cnt6", W'(out_am_count), W'(6), ones);
    for (int i = 17; i < 21; i++) begin
      tick();
      chk_out("t5_d", 1'b1, 1'b0, dat(i), ones);
      in_txdata = dat(i + 1);
    end
    chk("t5_cnt_restart", W'(in_ready), W'(0), ones);

    // Reversed lane ids
    cfg_lane_id = 12'o0123;
    tick();
    chk_out("t2_am7", 1'b1, 1'b1, am_exp(12'o0123), amask);
    chk("t2_lane0_id", W'(out_txdata[10:8]), W'(3), ones);
    chk("t2_lane3_id", W'(out_txdata[3*UW + 8 +: 3]), W'(0), ones);

    // Reset in mid-operation
    tick();
    chk_out("t6_d21", 1'b1, 1'b0, dat(21), ones);
    reset_n = 1'b0;
    tick();
    chk_out("t6_rst", 1'b0, 1'b0, '0, ones);
    chk("t6_rst_data", out_txdata, '0, ones);
    chk("t6_rst_cnt", W'(out_am_count), W'(0), ones);
    reset_n = 1'b1;
    tick();
    chk_out("t6_idle", 1'b0, 1'b0, '0, ones);
    tick();
    chk_out("t6_am", 1'b1, 1'b1, am_exp(12'o0123), amask);
    chk("t6_cnt1", W'(out_am_count), W'(1), ones);

`ifdef TX_AM_BIP_EN
    // Lane0 all 66'h1 for four blocks: parity cancels
    for (int i = 0; i < 4; i++) begin
      in_txdata = W'(1);
      tick();
      chk_out("t7_d", 1'b1, 1'b0, W'(1), ones);
    end
    tick();
    e = am_exp(12'o0123);
    for (int k = 0; k < LANES; k++) e[k*UW + 12 +: 8] = 8'h00;
    chk_out("t7_bip00", 1'b1, 1'b1, e, ones);
    // One block of 66'h1 then three zero blocks
    in_txdata = W'(1);
    tick();
    in_txdata = '0;
    tick(); tick(); tick();
    tick();
    e[12 +: 8] = 8'h01;
    chk_out("t7_bip01", 1'b1, 1'b1, e, ones);
`else
    e = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
